level_sequencer: RTL
====================

Name: level_sequencer

Overview:
Game-flow controller that sequences the playable levels. It holds the active level module in reset, releases it for play, and watches the level's win/lose flags. It counts lives, steps to the next level or replays the current one, and tells the renderer which screen to draw (title, playing, banner, game over, game complete). It sits between the top-level input/VGA wrapper and the per-level modules, and drives each level's active-low reset.

Parameters:
NUM_LEVELS, 3, number of levels in play order; level_index runs 0..NUM_LEVELS-1
START_LIVES, 3, lives loaded at game start; range 1..15
LOAD_CYCLES, 4, cycles level_reset_n is held low when a level is (re)loaded; must be >=1
BANNER_CYCLES, 50_000_000, cycles a win/lose banner is shown (2 s at 25 MHz); must be >=1

Ports:
vga_clock  input  1  system clock
reset  input  1  asynchronous, active-low
start_button  input  1  raw active-high button, asynchronous to vga_clock
level_win  input  1  active level's win flag; level-sensitive
level_lose  input  1  active level's lose flag; level-sensitive
level_reset_n  output  1  active-low reset to all level modules
level_index  output  $clog2(NUM_LEVELS) (min 1)  selects the active level and its outputs
lives  output  4  remaining lives
screen_mode  output  3  0=TITLE 1=PLAY 2=LEVEL_WON 3=LEVEL_LOST 4=GAME_OVER 5=GAME_DONE
busy  output  1  high in every state except TITLE, GAME_OVER and GAME_DONE

Behaviour:
- Reset (async assert, sync release): state TITLE, level_reset_n=0, level_index=0, lives=START_LIVES, screen_mode=0, busy=0. All counters cleared.
- start_button path: 2-flop synchronizer, then rising-edge detect. start_pulse is 1 cycle wide and asserts 3 cycles after the input rises. Holding the button gives exactly one pulse.
- All outputs are registered.
- level_reset_n=0 in TITLE, LOAD, GAME_OVER and GAME_DONE; 1 otherwise. Banners keep the level running so the frozen scene stays drawn.
- FSM:
  - TITLE: on start_pulse go to LOAD, with level_index=0 and lives=START_LIVES.
  - LOAD: load_cnt counts 0..LOAD_CYCLES-1. After LOAD_CYCLES cycles go to PLAY.
  - PLAY: win/lose are ignored on the first PLAY cycle (settle cycle; stale flags from the released level). From the second cycle on:
    - level_win=1 goes to WON. Win has priority when level_win and level_lose are both 1 in the same cycle.
    - level_lose=1 goes to LOST, and lives decrements in the same cycle.
    - start_pulse in PLAY is ignored.
  - WON: banner_cnt runs BANNER_CYCLES cycles.
    - If level_index==NUM_LEVELS-1, go to GAME_DONE.
    - Otherwise level_index increments and the FSM goes to LOAD.
  - LOST: banner_cnt runs BANNER_CYCLES cycles.
    - If lives==0, go to GAME_OVER.
    - Otherwise go to LOAD with the same level_index (replay).
  - GAME_OVER / GAME_DONE: hold. On start_pulse go to LOAD with level_index=0 and lives=START_LIVES.
- lives never decrements below 0. A lose seen with lives==0 is impossible by construction; the saturation guard is still required.
- banner_cnt and load_cnt clear on every state entry. BANNER_CYCLES=1 means exactly 1 cycle in the banner state.
- Reset mid-game (any state) returns to TITLE immediately, with all outputs at reset values.
- screen_mode tracks the state: LOAD reports 1 (PLAY), and WON/LOST report 2/3.

Test Plan:
(Bench parameters: NUM_LEVELS=2, START_LIVES=2, LOAD_CYCLES=4, BANNER_CYCLES=8.)
1. Reset, then pulse start_button for 1 cycle:
   - start_pulse asserts after 3 cycles.
   - level_reset_n stays 0 for exactly 4 cycles, then goes 1.
   - screen_mode=1, busy=1, lives=2, level_index=0.
2. In PLAY, assert level_win: screen_mode=2 for 8 cycles, then level_index=1, level_reset_n low for 4 cycles, then PLAY. A second win gives screen_mode=2 for 8 cycles, then screen_mode=5, level_reset_n=0, busy=0.
3. In PLAY, assert level_lose twice:
   - First lose: lives 2 to 1, screen_mode=3, level_index unchanged, then replay.
   - Second lose: lives 1 to 0, then screen_mode=4.
   - A start pulse then restarts with lives=2 and level_index=0.
4. Assert level_win and level_lose together from before PLAY entry:
   - Nothing happens on the first PLAY cycle.
   - On the second cycle, WON is entered and lives stays 2.
5. Hold start_button high through TITLE to LOAD to PLAY: exactly one start_pulse, and no restart when returning to GAME_OVER with the button still high.
6. Assert reset during WON banner cycle 3: outputs are immediately TITLE values (level_reset_n=0, lives=2, level_index=0, screen_mode=0).

Source files
------------

// File: rtl/level_sequencer_if.sv
// rtl/level_sequencer_if.sv - game-flow signals between the sequencer, the input wrapper and the level modules
interface level_sequencer_if #(
  parameter int IDX_W = 2
);
  logic             start_button;
  logic             level_win;
  logic             level_lose;
  logic             level_reset_n;
  logic [IDX_W-1:0] level_index;
  logic [3:0]       lives;
  logic [2:0]       screen_mode;
  logic             busy;

  modport master (
    input  start_button, level_win, level_lose,
    output level_reset_n, level_index, lives, screen_mode, busy
  );

  modport slave (
    output start_button, level_win, level_lose,
    input  level_reset_n, level_index, lives, screen_mode, busy
  );
endinterface

// File: rtl/level_sequencer.sv
// rtl/level_sequencer.sv - sequences levels, lives and screens; drives the level modules' reset
module level_sequencer #(
  parameter int NUM_LEVELS    = 3,
  parameter int START_LIVES   = 3,
  parameter int LOAD_CYCLES   = 4,
  parameter int BANNER_CYCLES = 50_000_000
) (
  input  logic              vga_clock,
  input  logic              reset,
  level_sequencer_if.master bus
);

  localparam int IDX_W   = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
  localparam int MAX_CNT = (LOAD_CYCLES > BANNER_CYCLES) ? LOAD_CYCLES : BANNER_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [IDX_W-1:0] LAST_LEVEL  = IDX_W'(NUM_LEVELS - 1);
  localparam logic [3:0]       LIVES_INIT  = 4'(START_LIVES);
  localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BANNER_LAST = CNT_W'(BANNER_CYCLES - 1);

  typedef enum logic [2:0] {
    S_TITLE,
    S_LOAD,
    S_PLAY,
    S_WON,
    S_LOST,
    S_GAME_OVER,
    S_GAME_DONE
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [IDX_W-1:0] index, index_next;
  logic [3:0]       lives, lives_next;
  logic             rstn_q, rstn_next;
  logic             busy_q, busy_next;
  logic [2:0]       mode_q, mode_next;

  logic rst_meta, rst_n;
  logic btn_meta, btn_sync, btn_prev, start_pulse;

  // Assertion reaches everything at once; release is retimed to vga_clock
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  always_ff @(posedge vga_clock or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta    <= 1'b0;
      btn_sync    <= 1'b0;
      btn_prev    <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      btn_meta    <= bus.start_button;
      btn_sync    <= btn_meta;
      btn_prev    <= btn_sync;
      start_pulse <= btn_sync & ~btn_prev;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    index_next = index;
    lives_next = lives;
    case (state)
      S_TITLE, S_GAME_OVER, S_GAME_DONE: begin
        if (start_pulse) begin
          state_next = S_LOAD;
          cnt_next   = '0;
          index_next = '0;
          lives_next = LIVES_INIT;
        end
      end
      S_LOAD: begin
        if (cnt == LOAD_LAST) begin
          state_next = S_PLAY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_PLAY: begin
        // cnt==0 marks the settle cycle, where flags may still be stale from the released level
        if (cnt == '0) begin
          cnt_next = CNT_W'(1);
        end else if (bus.level_win) begin
          state_next = S_WON;
          cnt_next   = '0;
        end else if (bus.level_lose) begin
          state_next = S_LOST;
          cnt_next   = '0;
          if (lives != 4'd0) lives_next = lives - 1'b1;
        end
      end
      S_WON: begin
        if (cnt == BANNER_LAST) begin
          cnt_next = '0;
          if (index == LAST_LEVEL) begin
            state_next = S_GAME_DONE;
          end else begin
            state_next = S_LOAD;
            index_next = index + 1'b1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_LOST: begin
        if (cnt == BANNER_LAST) begin
          cnt_next   = '0;
          state_next = (lives == 4'd0) ? S_GAME_OVER : S_LOAD;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = S_TITLE;
        cnt_next   = '0;
      end
    endcase

    rstn_next = (state_next == S_PLAY) || (state_next == S_WON) || (state_next == S_LOST);
    busy_next = !((state_next == S_TITLE) || (state_next == S_GAME_OVER) ||
                  (state_next == S_GAME_DONE));
    case (state_next)
      S_LOAD, S_PLAY: mode_next = 3'd1;
      S_WON:          mode_next = 3'd2;
      S_LOST:         mode_next = 3'd3;
      S_GAME_OVER:    mode_next = 3'd4;
      S_GAME_DONE:    mode_next = 3'd5;
      default:        mode_next = 3'd0;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state
  always_ff @(posedge vga_clock or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_TITLE;
      cnt    <= '0;
      index  <= '0;
      lives  <= LIVES_INIT;
      rstn_q <= 1'b0;
      busy_q <= 1'b0;
      mode_q <= 3'd0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      index  <= index_next;
      lives  <= lives_next;
      rstn_q <= rstn_next;
      busy_q <= busy_next;
      mode_q <= mode_next;
    end
  end

  assign bus.level_reset_n = rstn_q;
  assign bus.level_index   = index;
  assign bus.lives         = lives;
  assign bus.screen_mode   = mode_q;
  assign bus.busy          = busy_q;

endmodule
